// File: rtl/fb_scanout_pkg.sv
// Shared display definitions: RGB444 colour type and scanout pipeline depth.
package fb_scanout_pkg;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } colr_t;

   // One cycle to register the read request, RD_LAT for the memory, one for the colour register.
   function automatic int unsigned pipe_depth(input int unsigned rd_lat);
      return rd_lat + 2;
   endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register delay line with a configurable reset value.
module delay_line #(
   parameter int unsigned       WIDTH   = 1,
   parameter int unsigned       DEPTH   = 1,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   // Shift register; reset drives every stage to the idle value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RST_VAL;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: issues upscaled framebuffer reads and aligns sync/de with the returned pixels.
module fb_scanout
   import fb_scanout_pkg::*;
#(
   parameter int unsigned      CORDW     = 16,
   parameter int unsigned      FB_WIDTH  = 320,
   parameter int unsigned      FB_HEIGHT = 180,
   parameter int unsigned      SCALE     = 6,
   parameter int unsigned      ADDRW     = 16,
   parameter int unsigned      DATAW     = 12,
   parameter int unsigned      RD_LAT    = 2,
   parameter logic [DATAW-1:0] BG_COLR   = 12'h137,
   parameter bit               H_POL     = 1'b1,
   parameter bit               V_POL     = 1'b1
) (
   input  logic                    clk_pix,
   input  logic                    rst_pix,
   input  logic                    hsync,
   input  logic                    vsync,
   input  logic                    de,
   input  logic                    frame,
   input  logic                    line,
   input  logic signed [CORDW-1:0] sx,
   input  logic signed [CORDW-1:0] sy,
   output logic                    fb_rd,
   output logic [ADDRW-1:0]        fb_addr,
   input  logic [DATAW-1:0]        fb_data,
   output logic                    disp_hsync,
   output logic                    disp_vsync,
   output logic                    disp_de,
   output logic [DATAW-1:0]        disp_colr
);

   localparam int unsigned      PIPE      = pipe_depth(RD_LAT);
   localparam int unsigned      AREA_W    = FB_WIDTH * SCALE;
   localparam int unsigned      AREA_H    = FB_HEIGHT * SCALE;
   localparam int unsigned      CNTW      = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam logic [CNTW-1:0]  CNT_LAST  = CNTW'(SCALE - 1);
   localparam logic [ADDRW-1:0] LINE_STEP = ADDRW'(FB_WIDTH);
   localparam logic [1:0]       SYNC_IDLE = {H_POL ? 1'b0 : 1'b1, V_POL ? 1'b0 : 1'b1};

   // Configuration sanity checks at elaboration.
   if (longint'(FB_WIDTH) * longint'(FB_HEIGHT) > (longint'(1) << ADDRW)) begin : g_bad_size
      $error("fb_scanout: framebuffer does not fit in ADDRW address bits");
   end
   if (SCALE < 1) begin : g_bad_scale
      $error("fb_scanout: SCALE must be at least 1");
   end
   if (RD_LAT < 1) begin : g_bad_lat
      $error("fb_scanout: RD_LAT must be at least 1");
   end

   logic             in_area_c;
   logic             rd_en_c;
   logic             line_area_c;
   logic             ycnt_wrap_c;
   logic [ADDRW-1:0] line_base_next_c;

   logic [ADDRW-1:0] line_base;
   logic [ADDRW-1:0] addr;
   logic [CNTW-1:0]  xcnt;
   logic [CNTW-1:0]  ycnt;
   logic             started;

   logic             de_dly;
   logic             area_dly;

   // Area decode and the line_base value a line pulse would load.
   always_comb begin
      in_area_c        = de && (int'(sx) < int'(AREA_W)) && (int'(sy) < int'(AREA_H));
      line_area_c      = (int'(sy) >= 1) && (int'(sy) < int'(AREA_H));
      ycnt_wrap_c      = (ycnt == CNT_LAST);
      line_base_next_c = (line_area_c && ycnt_wrap_c) ? line_base + LINE_STEP : line_base;
      // No reads until a frame pulse has established the address state.
      rd_en_c          = in_area_c && started;
   end

   // Address generator: frame restarts, line reloads, pixels step every SCALE cycles.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         line_base <= '0;
         addr      <= '0;
         xcnt      <= '0;
         ycnt      <= '0;
         started   <= 1'b0;
      end else if (frame) begin
         line_base <= '0;
         addr      <= '0;
         xcnt      <= '0;
         ycnt      <= '0;
         started   <= 1'b1;
      end else if (line) begin
         if (line_area_c) ycnt <= ycnt_wrap_c ? '0 : ycnt + CNTW'(1);
         line_base <= line_base_next_c;
         addr      <= line_base_next_c;
         xcnt      <= '0;
      end else if (rd_en_c) begin
         if (xcnt == CNT_LAST) begin
            xcnt <= '0;
            addr <= addr + ADDRW'(1);
         end else begin
            xcnt <= xcnt + CNTW'(1);
         end
      end
   end

   // Read request register; the address holds while idle.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         fb_rd   <= 1'b0;
         fb_addr <= '0;
      end else begin
         fb_rd <= rd_en_c;
         if (rd_en_c) fb_addr <= addr;
      end
   end

   // Sync signals delayed by the full pipeline depth.
   delay_line #(
      .WIDTH   (2),
      .DEPTH   (PIPE),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_dly (
      .clk (clk_pix),
      .rst (rst_pix),
      .d   ({hsync, vsync}),
      .q   ({disp_hsync, disp_vsync})
   );

   // de and read-issued flag, aligned with fb_data one cycle before the output register.
   delay_line #(
      .WIDTH   (2),
      .DEPTH   (PIPE - 1),
      .RST_VAL (2'b00)
   ) u_area_dly (
      .clk (clk_pix),
      .rst (rst_pix),
      .d   ({de, rd_en_c}),
      .q   ({de_dly, area_dly})
   );

   // Output colour select; pixels without an issued read show the background.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         disp_de   <= 1'b0;
         disp_colr <= '0;
      end else begin
         disp_de <= de_dly;
         if (area_dly)    disp_colr <= fb_data;
         else if (de_dly) disp_colr <= BG_COLR;
         else             disp_colr <= '0;
      end
   end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: SCALE=2 and SCALE=1 instances on a small 4x2 framebuffer.
module tb_fb_scanout;
   import fb_scanout_pkg::*;

   localparam int    FBW     = 4;
   localparam int    FBH     = 2;
   localparam int    LAT     = 4;
   localparam int    H_BLANK = 4;
   localparam int    H_ACT   = 10;
   localparam int    V_BLANK = 2;
   localparam int    V_ACT   = 6;
   localparam colr_t BG_C    = '{r: 4'h1, g: 4'h3, b: 4'h7};

   typedef struct packed {
      logic        rd_a;
      logic [15:0] addr_a;
      logic        rd_b;
      logic [15:0] addr_b;
   } rd_exp_t;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] colr_a;
      logic [11:0] colr_b;
   } disp_exp_t;

   localparam rd_exp_t   RD_RST   = '0;
   localparam disp_exp_t DISP_RST = '0;

   logic               clk_pix = 1'b0;
   logic               rst_pix;
   logic               hsync, vsync, de, frame, line;
   logic signed [15:0] sx, sy;

   logic        fb_rd_a, fb_rd_b;
   logic [15:0] fb_addr_a, fb_addr_b;
   logic [11:0] fb_data_a, fb_data_b;
   logic [11:0] a_d1, a_d2, b_d1, b_d2;
   logic        dhs_a, dvs_a, dde_a, dhs_b, dvs_b, dde_b;
   logic [11:0] colr_a, colr_b;

   int          n_cmp = 0;
   int          n_bad = 0;
   rd_exp_t     rd_q[$];
   disp_exp_t   disp_q[$];
   logic        started;
   logic [15:0] last_a, last_b;

   always #5 clk_pix = ~clk_pix;

   fb_scanout #(
      .FB_WIDTH (FBW), .FB_HEIGHT (FBH), .SCALE (2), .RD_LAT (2), .BG_COLR (BG_C)
   ) dut_s2 (
      .clk_pix (clk_pix), .rst_pix (rst_pix), .hsync (hsync), .vsync (vsync), .de (de),
      .frame (frame), .line (line), .sx (sx), .sy (sy),
      .fb_rd (fb_rd_a), .fb_addr (fb_addr_a), .fb_data (fb_data_a),
      .disp_hsync (dhs_a), .disp_vsync (dvs_a), .disp_de (dde_a), .disp_colr (colr_a)
   );

   fb_scanout #(
      .FB_WIDTH (FBW), .FB_HEIGHT (FBH), .SCALE (1), .RD_LAT (2), .BG_COLR (BG_C)
   ) dut_s1 (
      .clk_pix (clk_pix), .rst_pix (rst_pix), .hsync (hsync), .vsync (vsync), .de (de),
      .frame (frame), .line (line), .sx (sx), .sy (sy),
      .fb_rd (fb_rd_b), .fb_addr (fb_addr_b), .fb_data (fb_data_b),
      .disp_hsync (dhs_b), .disp_vsync (dvs_b), .disp_de (dde_b), .disp_colr (colr_b)
   );

   // Framebuffer content; address 0 holds 12'hABC, no entry equals background or zero.
   function automatic logic [11:0] fb_word(input logic [15:0] a);
      return 12'hABC ^ 12'(a * 16'h111);
   endfunction

   // Two-cycle read memories; 12'hEEE marks a cycle with no read behind it.
   always @(posedge clk_pix) begin
      a_d1 <= fb_rd_a ? fb_word(fb_addr_a) : 12'hEEE;
      a_d2 <= a_d1;
      b_d1 <= fb_rd_b ? fb_word(fb_addr_b) : 12'hEEE;
      b_d2 <= b_d1;
   end
   assign fb_data_a = a_d2;
   assign fb_data_b = b_d2;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One pixel clock: check outputs due now, drive the next position, push its expectations.
   task automatic step(input logic r, input int x, input int y);
      rd_exp_t   re;
      disp_exp_t dx;
      logic      in_a, in_b;
      @(posedge clk_pix);
      #1;
      re = rd_q.pop_front();
      dx = disp_q.pop_front();
      chk("fb_rd_s2",      16'(fb_rd_a),   16'(re.rd_a));
      chk("fb_addr_s2",    fb_addr_a,      re.addr_a);
      chk("fb_rd_s1",      16'(fb_rd_b),   16'(re.rd_b));
      chk("fb_addr_s1",    fb_addr_b,      re.addr_b);
      chk("disp_hsync",    16'(dhs_a),     16'(dx.hs));
      chk("disp_vsync",    16'(dvs_a),     16'(dx.vs));
      chk("disp_de",       16'(dde_a),     16'(dx.de));
      chk("disp_colr_s2",  16'(colr_a),    16'(dx.colr_a));
      chk("disp_colr_s1",  16'(colr_b),    16'(dx.colr_b));
      chk("disp_sync_s1",  16'({dhs_b, dvs_b, dde_b}), 16'({dx.hs, dx.vs, dx.de}));

      rst_pix = r;
      sx      = 16'(x);
      sy      = 16'(y);
      de      = (x >= 0) && (y >= 0);
      line    = (x == -H_BLANK);
      frame   = (x == -H_BLANK) && (y == -V_BLANK);
      hsync   = (x == -3) || (x == -2);
      vsync   = (y == -V_BLANK);

      if (r) begin
         started = 1'b0;
         last_a  = '0;
         last_b  = '0;
         rd_q.delete();
         disp_q.delete();
         rd_q.push_back(RD_RST);
         repeat (LAT) disp_q.push_back(DISP_RST);
      end else begin
         in_a = de && (x < FBW * 2) && (y < FBH * 2) && started;
         in_b = de && (x < FBW) && (y < FBH) && started;
         if (in_a) last_a = 16'((y / 2) * FBW + x / 2);
         if (in_b) last_b = 16'(y * FBW + x);
         re.rd_a   = in_a;
         re.addr_a = last_a;
         re.rd_b   = in_b;
         re.addr_b = last_b;
         dx.hs     = hsync;
         dx.vs     = vsync;
         dx.de     = de;
         dx.colr_a = in_a ? fb_word(last_a) : (de ? BG_C : 12'h000);
         dx.colr_b = in_b ? fb_word(last_b) : (de ? BG_C : 12'h000);
         rd_q.push_back(re);
         disp_q.push_back(dx);
         if (frame) started = 1'b1;
      end
   endtask

   initial begin
      rst_pix = 1'b1;
      hsync   = 1'b0;
      vsync   = 1'b0;
      de      = 1'b0;
      frame   = 1'b0;
      line    = 1'b0;
      sx      = '0;
      sy      = '0;
      started = 1'b0;
      last_a  = '0;
      last_b  = '0;
      rd_q.push_back(RD_RST);
      repeat (LAT) disp_q.push_back(DISP_RST);

      repeat (3) step(1'b1, -1, -1);

      // Active lines before any frame pulse: background only, no reads.
      for (int y = 3; y < V_ACT; y++)
         for (int x = -H_BLANK; x < H_ACT; x++) step(1'b0, x, y);

      // Two complete frames; the second checks the restart after line_base has advanced.
      repeat (2)
         for (int y = -V_BLANK; y < V_ACT; y++)
            for (int x = -H_BLANK; x < H_ACT; x++) step(1'b0, x, y);

      // Frame interrupted by a reset at sx=3 on line 0, then no reads until the next frame.
      for (int y = -V_BLANK; y < V_ACT; y++)
         for (int x = -H_BLANK; x < H_ACT; x++) step((x == 3) && (y == 0), x, y);

      for (int y = -V_BLANK; y < V_ACT; y++)
         for (int x = -H_BLANK; x < H_ACT; x++) step(1'b0, x, y);

      repeat (LAT + 2) step(1'b0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
